pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Sequences the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register through three mechanisms:
- a data-memory wait state machine with timeout;
- load-use bubble insertion;
- branch/jump redirect flushing.

It sits beside the datapath and drives every pipeline register's `stop` and `flush` input.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum cycles spent in MEM_WAIT before the access is abandoned; legal range 1..255.
- `CNT_W`, default 32: width of the performance counters.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each: source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each: the ID instruction actually reads that source.
- `ex_rd`  in  5: destination register of the instruction in EX.
- `ex_is_load`  in  1: the EX instruction is a load.
- `ex_redirect`  in  1: a taken branch or jump resolved in EX.
- `dm_req`  in  1: valid load/store in MEM; held while MEM is frozen.
- `dm_ack`  in  1: one-cycle pulse; load data valid or store accepted.
- `pc_stop`, `ifid_stop`, `idex_stop`, `exmem_stop`, `memwb_stop`  out  1 each: hold the register.
- `ifid_flush`, `idex_flush`, `memwb_flush`  out  1 each: load a bubble (all zeros) instead of the input.
- `bus_err`  out  1: registered one-cycle pulse on timeout.
- `stall_cycles`, `flush_events`  out  `CNT_W` each: present only with `PIPE_PERF_EN`.

## Operation
States are RUN and MEM_WAIT; a wait counter `wait_cnt` is 8 bits wide.

Stop/flush outputs are combinational from state and inputs, evaluated in priority order:
1. **Memory freeze.** Condition: (RUN and `dm_req` and not `dm_ack`), or (MEM_WAIT and not `dm_ack` and `wait_cnt` < `MEM_TIMEOUT`).
   - All five stops are 1; all flushes are 0.
   - Every other rule is suppressed.
2. **Timeout.** Condition: MEM_WAIT and not `dm_ack` and `wait_cnt` == `MEM_TIMEOUT`.
   - All stops are 0.
   - `memwb_flush` is 1, so the abandoned access never writes back.
   - Rules 3 and 4 are still evaluated this cycle.
3. **Redirect.** Condition: `ex_redirect`.
   - `ifid_flush` = 1 and `idex_flush` = 1; the PC loads the target, so `pc_stop` = 0.
   - The load-use rule is ignored because the consumer is flushed.
4. **Load-use.** Condition: `ex_is_load` and `ex_rd` != 0 and ((`id_rs1_used` and `id_rs1` == `ex_rd`) or (`id_rs2_used` and `id_rs2` == `ex_rd`)).
   - `pc_stop` = 1, `ifid_stop` = 1, `idex_flush` = 1 (one bubble).
5. **Default.** All outputs are 0.

State transitions:
- RUN → MEM_WAIT when `dm_req` and not `dm_ack`; `wait_cnt` ← 1.
- MEM_WAIT, no `dm_ack`, `wait_cnt` < `MEM_TIMEOUT`: stay; `wait_cnt` increments.
- MEM_WAIT with `dm_ack`: → RUN, `wait_cnt` ← 0.
  - All stops drop in this cycle, so MEM/WB captures the data on the same edge.
- MEM_WAIT at timeout: → RUN, `wait_cnt` ← 0, `bus_err` ← 1 on the next edge.

## Timing
Reset:
- State = RUN, `wait_cnt` = 0, `bus_err` = 0, counters = 0.
- While `rst` is high, the combinational outputs still decode from RUN.
- A reset during MEM_WAIT returns to RUN on the next edge; no `bus_err` is raised.

Latencies:
- Stop/flush outputs have zero-cycle latency (same-cycle combinational).
- `bus_err` lags the timeout cycle by one edge.

Handshake and timing rules:
- A single-cycle memory (`dm_ack` in the same cycle as `dm_req`) causes no stall.
- `dm_ack` in RUN without `dm_req` is ignored.
- A redirect or load-use raised during a freeze is held by the frozen registers and takes effect in the release cycle.
- Load-use costs exactly 1 bubble; the next cycle the load sits in MEM and forwarding resolves the dependency.
- A `dm_ack` arriving in the same cycle as the timeout condition counts as an ack, not a timeout.

## Configuration
`PIPE_PERF_EN` adds the two performance counters.

With the macro defined:
- `stall_cycles` increments every cycle `pc_stop` is 1.
- `flush_events` increments every cycle any flush output is 1.
- Both saturate at all-ones and clear on `rst`.

Without the macro: the counter ports and their logic are absent.

## Structure
Shared package `pipe_ctrl_pkg` holds:
- state encodings: `ST_RUN` = 1'b0, `ST_MEM_WAIT` = 1'b1;
- `REG_ADDR_W` = 5;
- the bubble value, 32'h0000_0013 (NOP) for `inst` fields.

Sub-module `pipe_perf_cnt` is one saturating counter with an enable input, instantiated twice under `PIPE_PERF_EN`.

## Test plan
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 → `pc_stop`=`ifid_stop`=`idex_flush`=1 for exactly 1 cycle. With `ex_rd`=0 → no stall.
- **Memory wait:** `dm_req`=1, `dm_ack` arrives 3 cycles later → all stops high for 3 cycles, then 0 in the ack cycle; state returns to RUN.
- **Timeout:** `MEM_TIMEOUT`=4, `dm_req` held, no ack → stops high for 4 cycles; `memwb_flush`=1 in the 5th; `bus_err` pulses the following cycle.
- **Redirect vs load-use:** `ex_redirect`=1 together with a load-use match → `ifid_flush`=`idex_flush`=1 and `pc_stop`=0.
- **Redirect during freeze:** `ex_redirect` held while in MEM_WAIT → no flush until the `dm_ack` cycle, then flush in that cycle.
- **Counters (`PIPE_PERF_EN`):** one load-use, one 3-cycle wait and one redirect → `stall_cycles`=4, `flush_events`=2. `rst` mid-wait → state RUN and counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   ST_RUN / ST_MEM_WAIT : controller state encoding
//   REG_ADDR_W           : architectural register index width
//   BUBBLE_INST          : instruction word used for flushed inst fields (NOP)
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam int REG_ADDR_W = 5;

  localparam logic [31:0] BUBBLE_INST = 32'h0000_0013;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter.
//   clk : clock
//   rst : synchronous active-high clear
//   en  : count this cycle
//   cnt : current count, sticks at all-ones
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives stop/flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
// data-memory wait (with timeout), load-use bubble insertion, EX redirect.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used         : sources of the ID instruction
//   ex_rd, ex_is_load             : destination / load flag of the EX instruction
//   ex_redirect                   : taken branch or jump resolved in EX
//   dm_req, dm_ack                : data-memory request (held) and ack pulse
//   *_stop, *_flush               : combinational register controls
//   bus_err                       : registered pulse one edge after a timeout
//   stall_cycles, flush_events    : saturating counters (only with PIPE_PERF_EN)
//
// Build option: define PIPE_PERF_EN to add the two performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic                  dm_req,
  input  logic                  dm_ack,
  output logic                  pc_stop,
  output logic                  ifid_stop,
  output logic                  idex_stop,
  output logic                  exmem_stop,
  output logic                  memwb_stop,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  bus_err
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);

  if (CNT_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_param
    $error("pipe_hazard_ctrl: CNT_W must be >= 1 and MEM_TIMEOUT in 1..255");
  end

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_d;

  logic       freeze;
  logic       timeout;
  logic       load_use;

  // The >= on the timeout side means an out-of-range count can never wedge
  // the controller in MEM_WAIT; in normal operation it only ever equals TMO.
  assign freeze   = ((state_q == ST_RUN) && dm_req && !dm_ack) ||
                    ((state_q == ST_MEM_WAIT) && !dm_ack && (wait_cnt_q < TMO));
  assign timeout  = (state_q == ST_MEM_WAIT) && !dm_ack && (wait_cnt_q >= TMO);
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    pc_stop     = 1'b0;
    ifid_stop   = 1'b0;
    idex_stop   = 1'b0;
    exmem_stop  = 1'b0;
    memwb_stop  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    if (freeze) begin
      // Whole pipe holds; redirect/load-use stay latched in the frozen
      // registers and are acted on in the release cycle.
      pc_stop    = 1'b1;
      ifid_stop  = 1'b1;
      idex_stop  = 1'b1;
      exmem_stop = 1'b1;
      memwb_stop = 1'b1;
    end else begin
      // Abandoned access must not write back; the front end keeps going.
      if (timeout) begin
        memwb_flush = 1'b1;
      end
      // A redirect kills the consumer, so a load-use match is moot.
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stop    = 1'b1;
        ifid_stop  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (dm_req && !dm_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the timeout cycle wins over the timeout.
        if (dm_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < TMO) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          bus_err_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      bus_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err    <= bus_err_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic any_flush;
  assign any_flush = ifid_flush | idex_flush | memwb_flush;

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_stop),
    .cnt (stall_cycles)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (any_flush),
    .cnt (flush_events)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table of single-cycle vectors plus hand-written
// multi-cycle sequences; expected outputs go through a scoreboard queue.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 16;

  // Expected output vector order:
  // {pc, ifid, idex, exmem, memwb stops, ifid, idex, memwb flushes, bus_err}
  localparam logic [8:0] E_IDLE  = 9'b00000_000_0;
  localparam logic [8:0] E_FRZ   = 9'b11111_000_0;
  localparam logic [8:0] E_LU    = 9'b11000_010_0;
  localparam logic [8:0] E_RD    = 9'b00000_110_0;
  localparam logic [8:0] E_TO    = 9'b00000_001_0;
  localparam logic [8:0] E_TO_RD = 9'b00000_111_0;
  localparam logic [8:0] E_TO_LU = 9'b11000_011_0;
  localparam logic [8:0] E_BE    = 9'b00000_000_1;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, dm_req, dm_ack;
  logic       pc_stop, ifid_stop, idex_stop, exmem_stop, memwb_stop;
  logic       ifid_flush, idex_flush, memwb_flush, bus_err;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_redirect (ex_redirect),
    .dm_req      (dm_req),
    .dm_ack      (dm_ack),
    .pc_stop     (pc_stop),
    .ifid_stop   (ifid_stop),
    .idex_stop   (idex_stop),
    .exmem_stop  (exmem_stop),
    .memwb_stop  (memwb_stop),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .memwb_flush (memwb_flush),
    .bus_err     (bus_err)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {pc_stop, ifid_stop, idex_stop, exmem_stop, memwb_stop,
                 ifid_flush, idex_flush, memwb_flush, bus_err};

  typedef struct {
    string      name;
    logic       rst, req, ack, redir, ld;
    logic [4:0] rd, rs1, rs2;
    logic       rs1u, rs2u;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic vec_t mk(string name, logic r, logic req, logic ack,
                              logic redir, logic ld, logic [4:0] rd,
                              logic [4:0] rs1, logic rs1u,
                              logic [4:0] rs2, logic rs2u, logic [8:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.req = req; v.ack = ack; v.redir = redir;
    v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2;
    v.rs2u = rs2u; v.exp = exp;
    return v;
  endfunction

  // Shorthands for the control-only cycles of the multi-cycle sequences.
  function automatic vec_t mc(string name, logic r, logic req, logic ack,
                              logic redir, logic [8:0] exp);
    return mk(name, r, req, ack, redir, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, exp);
  endfunction

  task automatic step(input vec_t v);
    rst         = v.rst;
    dm_req      = v.req;
    dm_ack      = v.ack;
    ex_redirect = v.redir;
    ex_is_load  = v.ld;
    ex_rd       = v.rd;
    id_rs1      = v.rs1;
    id_rs1_used = v.rs1u;
    id_rs2      = v.rs2;
    id_rs2_used = v.rs2u;
    sb_q.push_back('{v.name, v.exp});
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs settle after the drive at posedge+1, sampled at negedge.
  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (outs === e.exp) n_pass++;
      else $display("FAIL %s: outputs got %b expected %b", e.name, outs, e.exp);
    end
  end

`ifdef PIPE_PERF_EN
  task automatic check_cnt(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
`endif

  vec_t tbl[$];

  initial begin
    rst = 1'b1; dm_req = 1'b0; dm_ack = 1'b0; ex_redirect = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    @(posedge clk);
    #1;

    // Reset behaviour: outputs decode from RUN while rst is held.
    step(mc("rst_idle", 1, 0, 0, 0, E_IDLE));
    step(mc("rst_req_run_decode", 1, 1, 0, 0, E_FRZ));

    // Single-cycle vectors, all leave the controller in RUN.
    tbl.push_back(mk("idle",          0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_IDLE));
    tbl.push_back(mk("lu_rs1",        0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, E_LU));
    tbl.push_back(mk("lu_rd_x0",      0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, E_IDLE));
    tbl.push_back(mk("lu_rs2",        0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, E_LU));
    tbl.push_back(mk("lu_rs1_unused", 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd1, 1, E_IDLE));
    tbl.push_back(mk("match_no_load", 0, 0, 0, 0, 0, 5'd9, 5'd9, 1, 5'd9, 1, E_IDLE));
    tbl.push_back(mk("redir_over_lu", 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, E_RD));
    tbl.push_back(mk("redir_only",    0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_RD));
    tbl.push_back(mk("mem_1cycle",    0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_IDLE));
    tbl.push_back(mk("ack_no_req",    0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, E_IDLE));
    tbl.push_back(mk("mem_1cycle_lu", 0, 1, 1, 0, 1, 5'd4, 5'd1, 0, 5'd4, 1, E_LU));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Memory wait: ack three cycles after the request.
    for (int i = 0; i < 3; i++) step(mc("wait_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("wait_ack", 0, 1, 1, 0, E_IDLE));
    step(mc("wait_back_run", 0, 0, 0, 0, E_IDLE));

    // Redirect held during a freeze acts only in the release cycle.
    for (int i = 0; i < 2; i++) step(mc("redir_frz", 0, 1, 0, 1, E_FRZ));
    step(mc("redir_release", 0, 1, 1, 1, E_RD));
    step(mc("redir_after", 0, 0, 0, 0, E_IDLE));

    // Timeout.
    for (int i = 0; i < TMO; i++) step(mc("to_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("to_cycle", 0, 1, 0, 0, E_TO));
    step(mc("to_bus_err", 0, 0, 0, 0, E_BE));
    step(mc("to_bus_err_clr", 0, 0, 0, 0, E_IDLE));

    // Timeout combined with redirect, then with load-use.
    for (int i = 0; i < TMO; i++) step(mc("to_rd_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("to_with_redir", 0, 1, 0, 1, E_TO_RD));
    step(mc("to_rd_bus_err", 0, 0, 0, 0, E_BE));
    for (int i = 0; i < TMO; i++) step(mc("to_lu_frz", 0, 1, 0, 0, E_FRZ));
    step(mk("to_with_lu", 0, 1, 0, 0, 1, 5'd6, 5'd6, 1, 5'd0, 0, E_TO_LU));
    step(mc("to_lu_bus_err", 0, 0, 0, 0, E_BE));

    // Ack in the timeout cycle counts as an ack.
    for (int i = 0; i < TMO; i++) step(mc("ack_at_to_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("ack_at_to", 0, 1, 1, 0, E_IDLE));
    step(mc("ack_at_to_no_err", 0, 0, 0, 0, E_IDLE));

    // Reset in the middle of a wait.
    for (int i = 0; i < 2; i++) step(mc("rst_mid_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("rst_mid_edge", 1, 1, 0, 0, E_FRZ));
    step(mc("rst_mid_run", 1, 0, 0, 0, E_IDLE));
    step(mc("rst_mid_after", 0, 0, 0, 0, E_IDLE));

    // Reset in the timeout cycle suppresses bus_err.
    for (int i = 0; i < TMO; i++) step(mc("rst_to_frz", 0, 1, 0, 0, E_FRZ));
    step(mc("rst_to_cycle", 1, 1, 0, 0, E_TO));
    step(mc("rst_to_no_err", 0, 0, 0, 0, E_IDLE));

`ifdef PIPE_PERF_EN
    step(mc("perf_rst", 1, 0, 0, 0, E_IDLE));
    check_cnt("stall_after_rst", stall_cycles, '0);
    check_cnt("flush_after_rst", flush_events, '0);
    step(mk("perf_lu", 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, E_LU));
    for (int i = 0; i < 3; i++) step(mc("perf_wait", 0, 1, 0, 0, E_FRZ));
    step(mc("perf_ack", 0, 1, 1, 0, E_IDLE));
    step(mc("perf_redir", 0, 0, 0, 1, E_RD));
    check_cnt("stall_cycles", stall_cycles, CNT_W'(4));
    check_cnt("flush_events", flush_events, CNT_W'(2));
    for (int i = 0; i < 2; i++) step(mc("perf_mid_wait", 0, 1, 0, 0, E_FRZ));
    step(mc("perf_rst_mid", 1, 0, 0, 0, E_FRZ));
    check_cnt("stall_rst_mid", stall_cycles, '0);
    check_cnt("flush_rst_mid", flush_events, '0);
    step(mc("perf_run_after_rst", 0, 0, 0, 0, E_IDLE));
`endif

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
